// File: rtl/pulse_gap_regulator_pkg.sv
// Shared types for the pulse gap regulator: FSM state encoding and drop-counter width.
package pulse_gap_pkg;

  typedef enum logic [1:0] {IDLE, EMIT, GAP} gap_state_t;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/pulse_gap_regulator_sat_updown_cnt.sv
// Saturating up/down counter holding the number of pending events.
// An inc that coincides with a dec leaves the count unchanged.
// An inc that arrives while the counter is full is reported on drop.
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         gclk,
  input  logic         grst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         drop
);

  assign full = &count;
  assign drop = inc && !dec && full;

  // Count up or down. The count sticks at max, and never goes below zero.
  always_ff @(posedge gclk) begin
    if (grst) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pulse_gap_regulator.sv
// pulse_gap_regulator: paces single-cycle event pulses so that successive o_pulse
// rising edges are at least MIN_GAP source cycles apart. Events that cannot be
// emitted yet wait in a saturating counter. Events lost at saturation set a sticky flag.
// Optional build macro PULSE_GAP_STATS_EN adds o_drop_cnt, a saturating 8-bit
// count of dropped events.
module pulse_gap_regulator
  import pulse_gap_pkg::*;
#(
  parameter int MIN_GAP = 6,
  parameter int CNT_W   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pulse,
  input  logic                  i_ovf_clr,
  output logic                  o_pulse,
  output logic [CNT_W-1:0]      o_pending,
  output logic                  o_overflow,
  output logic                  o_busy
`ifdef PULSE_GAP_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
`endif
);

  localparam int GW = $clog2(MIN_GAP);
  // gap_cnt reaches zero in the last GAP cycle, so EMIT plus GAP last MIN_GAP cycles.
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 2);

  gap_state_t    state;
  logic [GW-1:0] gap_cnt;
  logic          take;
  logic          drop;
  logic          pend_full_unused;

  // A new pulse is launched from IDLE, or from the last GAP cycle. This keeps
  // back-to-back emissions exactly MIN_GAP apart, with no idle bubble.
  assign take = ((state == IDLE) || ((state == GAP) && (gap_cnt == '0))) &&
                ((o_pending != '0) || i_pulse);

  assign o_busy = (state != IDLE) || (o_pending != '0);

  sat_updown_cnt #(.W(CNT_W)) u_pending (
    .gclk  (i_clk),
    .grst  (i_rst),
    .inc   (i_pulse),
    .dec   (take),
    .count (o_pending),
    .full  (pend_full_unused),
    .drop  (drop)
  );

  // Pacing FSM: EMIT is the single o_pulse cycle, and GAP holds off the next one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      o_pulse <= 1'b0;
    end else begin
      o_pulse <= take;
      case (state)
        IDLE: if (take) state <= EMIT;
        EMIT: begin
          state   <= GAP;
          gap_cnt <= GAP_LOAD;
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
          else               state   <= take ? EMIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow flag. A drop in the same cycle overrides a clear.
  always_ff @(posedge i_clk) begin
    if (i_rst)          o_overflow <= 1'b0;
    else if (drop)      o_overflow <= 1'b1;
    else if (i_ovf_clr) o_overflow <= 1'b0;
  end

`ifdef PULSE_GAP_STATS_EN
  // Drop statistics. The count saturates at all-ones. An increment that meets a clear restarts at 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_drop_cnt <= '0;
    end else if (drop) begin
      if (i_ovf_clr)         o_drop_cnt <= DROP_CNT_W'(1);
      else if (~&o_drop_cnt) o_drop_cnt <= o_drop_cnt + DROP_CNT_W'(1);
    end else if (i_ovf_clr) begin
      o_drop_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_gap_regulator.sv
// Self-checking bench for pulse_gap_regulator. A behavioural model tracks the
// backlog and the cycle of the last emitted pulse. It emits whenever an event is
// available and at least MIN_GAP cycles have passed since the previous pulse.
module tb_pulse_gap_regulator;

  localparam int MIN_GAP = 6;
  localparam int CNT_W   = 4;
  localparam int MAXP    = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_pulse = 1'b0;
  logic             i_ovf_clr = 1'b0;
  logic             o_pulse;
  logic [CNT_W-1:0] o_pending;
  logic             o_overflow;
  logic             o_busy;
`ifdef PULSE_GAP_STATS_EN
  logic [7:0]       o_drop_cnt;
`endif

  pulse_gap_regulator #(.MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_pulse    (i_pulse),
    .i_ovf_clr  (i_ovf_clr),
    .o_pulse    (o_pulse),
    .o_pending  (o_pending),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
`ifdef PULSE_GAP_STATS_EN
    ,
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  int m_pending = 0;
  int m_last    = -1000;
  int m_cyc     = 0;
  int m_drop    = 0;
  bit m_pulse   = 1'b0;
  bit m_ovf     = 1'b0;

  function automatic bit m_busy();
    return (m_pending != 0) || (m_cyc - m_last < MIN_GAP);
  endfunction

  // Drive one edge's inputs, advance the model by that edge, then settle past the edge.
  task automatic tick(input bit p, input bit clr = 1'b0, input bit r = 1'b0);
    bit emit;
    bit dropped;
    i_pulse = p; i_ovf_clr = clr; i_rst = r;
    @(posedge i_clk);
    if (r) begin
      m_pending = 0; m_last = -1000; m_pulse = 1'b0; m_ovf = 1'b0; m_drop = 0;
    end else begin
      emit    = (m_cyc + 1 - m_last >= MIN_GAP) && (m_pending > 0 || p);
      dropped = p && !emit && (m_pending == MAXP);
      if (emit) begin
        m_last    = m_cyc + 1;
        m_pending = m_pending + int'(p) - 1;
      end else if (p && !dropped) begin
        m_pending++;
      end
      m_pulse = emit;
      if (dropped) begin
        m_ovf  = 1'b1;
        m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      end else if (clr) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
    end
    m_cyc++;
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    n_total++; if (o_pulse !== 1'b0) $display("FAIL reset_pulse: got %0b want 0", o_pulse); else n_pass++;
    n_total++; if (o_pending !== '0) $display("FAIL reset_pending: got %0d want 0", o_pending); else n_pass++;
    n_total++; if (o_overflow !== 1'b0) $display("FAIL reset_overflow: got %0b want 0", o_overflow); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", o_busy); else n_pass++;
`ifdef PULSE_GAP_STATS_EN
    n_total++; if (o_drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt: got %0d want 0", o_drop_cnt); else n_pass++;
`endif
  endtask

  task automatic test_single();
    do_reset();
    tick(1'b1);
    n_total++; if (o_pulse !== 1'b1) $display("FAIL single_pulse_c1: got %0b want 1", o_pulse); else n_pass++;
    n_total++; if (o_pending !== '0) $display("FAIL single_pending_c1: got %0d want 0", o_pending); else n_pass++;
    for (int c = 2; c <= 6; c++) begin
      tick(1'b0);
      n_total++;
      if ({o_busy, o_pulse, o_pending} !== {2'b10, {CNT_W{1'b0}}})
        $display("FAIL single_busy_c%0d: got busy=%0b pulse=%0b pend=%0d want busy=1 pulse=0 pend=0",
                 c, o_busy, o_pulse, o_pending);
      else n_pass++;
    end
    tick(1'b0);
    n_total++; if (o_busy !== 1'b0) $display("FAIL single_busy_c7: got %0b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_burst4();
    int q[$];
    int peak;
    peak = 0;
    do_reset();
    for (int c = 1; c <= 25; c++) begin
      tick(c <= 4);
      if (int'(o_pending) > peak) peak = int'(o_pending);
      if (o_pulse) q.push_back(c);
    end
    n_total++; if (q.size() !== 4) $display("FAIL burst4_count: got %0d want 4", q.size()); else n_pass++;
    for (int i = 0; i < q.size() && i < 4; i++) begin
      n_total++;
      if (q[i] !== 1 + 6 * i) $display("FAIL burst4_pos%0d: got cycle %0d want %0d", i, q[i], 1 + 6 * i);
      else n_pass++;
    end
    n_total++; if (peak !== 3) $display("FAIL burst4_peak: got %0d want 3", peak); else n_pass++;
    n_total++; if (o_pending !== '0) $display("FAIL burst4_final_pending: got %0d want 0", o_pending); else n_pass++;
  endtask

  task automatic test_saturate();
    int q[$];
    int bad;
    bad = 0;
    do_reset();
    for (int e = 0; e < 140; e++) begin
      tick(e <= 19);
      if (o_pulse) q.push_back(e + 1);
      if (e == 18) begin
        n_total++; if (o_pending !== 4'd15) $display("FAIL sat_pending_e18: got %0d want 15", o_pending); else n_pass++;
        n_total++; if (o_overflow !== 1'b0) $display("FAIL sat_ovf_e18: got %0b want 0", o_overflow); else n_pass++;
      end
      if (e == 19) begin
        n_total++; if (o_overflow !== 1'b1) $display("FAIL sat_ovf_e19: got %0b want 1", o_overflow); else n_pass++;
        n_total++; if (o_pending !== 4'd15) $display("FAIL sat_pending_e19: got %0d want 15", o_pending); else n_pass++;
`ifdef PULSE_GAP_STATS_EN
        n_total++; if (o_drop_cnt !== 8'd1) $display("FAIL sat_drop_cnt: got %0d want 1", o_drop_cnt); else n_pass++;
`endif
      end
    end
    n_total++; if (q.size() !== 19) $display("FAIL sat_pulse_count: got %0d want 19", q.size()); else n_pass++;
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != MIN_GAP) bad++;
    n_total++; if (bad !== 0) $display("FAIL sat_spacing: got %0d bad gaps want 0", bad); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL sat_final_busy: got %0b want 0", o_busy); else n_pass++;
  endtask

  task automatic test_gap_edge();
    do_reset();
    tick(1'b1);
    n_total++; if (o_pulse !== 1'b1) $display("FAIL gapedge_first: got %0b want 1", o_pulse); else n_pass++;
    for (int c = 2; c <= 6; c++) tick(1'b0);
    n_total++; if ({o_pulse, o_busy} !== 2'b01) $display("FAIL gapedge_c6: got pulse=%0b busy=%0b want pulse=0 busy=1", o_pulse, o_busy); else n_pass++;
    tick(1'b1);
    n_total++; if (o_pulse !== 1'b1) $display("FAIL gapedge_c7: got %0b want 1", o_pulse); else n_pass++;
    n_total++; if (o_pending !== '0) $display("FAIL gapedge_pending: got %0d want 0", o_pending); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int np;
    np = 0;
    do_reset();
    for (int e = 0; e < 6; e++) tick(1'b1);
    n_total++; if (o_pending !== 4'd5) $display("FAIL rstmid_pending: got %0d want 5", o_pending); else n_pass++;
    tick(1'b1, 1'b0, 1'b1);
    n_total++;
    if ({o_pulse, o_pending, o_overflow, o_busy} !== '0)
      $display("FAIL rstmid_outputs: got pulse=%0b pend=%0d ovf=%0b busy=%0b want all 0", o_pulse, o_pending, o_overflow, o_busy);
    else n_pass++;
    for (int c = 0; c < 12; c++) begin
      tick(1'b0);
      if (o_pulse) np++;
    end
    n_total++; if (np !== 0) $display("FAIL rstmid_no_pulse: got %0d pulses want 0", np); else n_pass++;
  endtask

  task automatic test_ovf_clr();
    do_reset();
    for (int e = 0; e < 20; e++) tick(1'b1, 1'b1);
    n_total++; if (o_overflow !== 1'b1) $display("FAIL ovfclr_set_wins: got %0b want 1", o_overflow); else n_pass++;
`ifdef PULSE_GAP_STATS_EN
    n_total++; if (o_drop_cnt !== 8'd1) $display("FAIL ovfclr_drop_cnt: got %0d want 1", o_drop_cnt); else n_pass++;
`endif
    tick(1'b0, 1'b1);
    n_total++; if (o_overflow !== 1'b0) $display("FAIL ovfclr_clear: got %0b want 0", o_overflow); else n_pass++;
`ifdef PULSE_GAP_STATS_EN
    n_total++; if (o_drop_cnt !== 8'd0) $display("FAIL ovfclr_drop_clear: got %0d want 0", o_drop_cnt); else n_pass++;
`endif
  endtask

  task automatic test_random();
    int thresh;
    bit p, c, r;
    do_reset();
    for (int i = 0; i < 900; i++) begin
      if (i % 100 == 0) thresh = (i / 100 % 3 == 0) ? 10 : ((i / 100 % 3 == 1) ? 45 : 95);
      p = ($urandom_range(0, 99) < thresh);
      c = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 299) == 0);
      tick(p, c, r);
      n_total++;
      if ({o_pulse, o_pending, o_overflow, o_busy} !== {m_pulse, CNT_W'(m_pending), m_ovf, m_busy()})
        $display("FAIL random_c%0d: got pulse=%0b pend=%0d ovf=%0b busy=%0b want pulse=%0b pend=%0d ovf=%0b busy=%0b",
                 i, o_pulse, o_pending, o_overflow, o_busy, m_pulse, m_pending, m_ovf, m_busy());
      else n_pass++;
`ifdef PULSE_GAP_STATS_EN
      n_total++;
      if (o_drop_cnt !== 8'(m_drop)) $display("FAIL random_drop_c%0d: got %0d want %0d", i, o_drop_cnt, m_drop);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst4();
    test_saturate();
    test_gap_edge();
    test_reset_mid();
    test_ovf_clr();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pulse_gap_regulator.md
# pulse_gap_regulator

Fast-domain pacing stage that sits directly upstream of the fast-to-slow pulse toggle synchronizer. It accepts single-cycle event pulses at any rate and counts pending events in a saturating counter. It re-emits the events as single-cycle pulses spaced at least MIN_GAP source-clock cycles apart, so the toggle synchronizer never receives two pulses closer than the destination domain can resolve. Drops caused by counter saturation are flagged sticky.

## Interface
- MIN_GAP, 6, source cycles between successive o_pulse rising edges; legal range ≥ 2
- CNT_W, 4, width of the pending-event counter; max pending = 2^CNT_W − 1
- i_clk  in  1  source (fast) clock; single clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_pulse  in  1  event input; each cycle sampled high = one event
- i_ovf_clr  in  1  clears o_overflow (and drop count when compiled in)
- o_pulse  out  1  paced single-cycle output pulse, registered; feeds the toggle synchronizer i_pulse
- o_pending  out  CNT_W  events accepted but not yet emitted
- o_overflow  out  1  sticky; an event was dropped at saturation
- o_busy  out  1  high when state ≠ IDLE or o_pending ≠ 0

## Operation
- States (enum): IDLE, EMIT, GAP; gap counter gap_cnt, width $clog2(MIN_GAP).
- take = (state==IDLE || (state==GAP && gap_cnt==0)) && (o_pending≠0 || i_pulse).
- take → next state EMIT; o_pulse=1 for exactly that cycle.
- EMIT → GAP always; gap_cnt loads MIN_GAP−2.
- GAP: gap_cnt decrements; at gap_cnt==0, go to EMIT if take, else IDLE.
- Pending update: next = o_pending + i_pulse − take.
- Saturation: i_pulse && !take && o_pending==MAX → o_pending stays MAX; event dropped; o_overflow set.
- Direct path: IDLE, o_pending==0, i_pulse=1 → EMIT; o_pending stays 0.
- Simultaneous i_pulse and take: o_pending unchanged.
- i_ovf_clr together with a drop in the same cycle: set wins; o_overflow stays 1.
- Events are never reordered or merged; every accepted event produces exactly one o_pulse.

## Timing
- Reset values: o_pulse=0, o_pending=0, o_overflow=0, o_busy=0, state=IDLE, gap_cnt=0, drop count=0.
- Latency: i_pulse sampled at edge N in IDLE with o_pending=0 → o_pulse high in cycle N+1.
- Spacing: o_pulse rising edges are exactly MIN_GAP cycles apart while events are pending; never fewer.
- o_pulse is never high in two consecutive cycles.
- Reset mid-operation: pending events are discarded; i_pulse during reset is ignored; o_pulse is low the cycle after the reset edge.
- o_busy is combinational from registered state only.

## Configuration
- PULSE_GAP_STATS_EN defined:
  - Adds output o_drop_cnt [7:0], a saturating count of dropped events (sticks at 255).
  - Cleared by i_rst or i_ovf_clr.
  - Increment wins over a same-cycle clear: the count becomes 1.
- Undefined: o_drop_cnt port and its logic are absent; all other behaviour is identical.

## Structure
- Package pulse_gap_pkg holds:
  - typedef enum logic [1:0] {IDLE, EMIT, GAP} gap_state_t
  - localparam DROP_CNT_W = 8
- One sub-module is natural: sat_updown_cnt, a saturating up/down counter (parameter W; inputs inc, dec; outputs count, full, drop). It is used for o_pending.

## Test plan
All scenarios use MIN_GAP=6, CNT_W=4; edge 0 is the first post-reset i_pulse edge.
- Single pulse after reset → one o_pulse in cycle 1; o_busy high cycles 1–6, low at cycle 7; o_pending stays 0.
- i_pulse high 4 consecutive cycles → o_pulse in cycles 1, 7, 13, 19; o_pending peaks at 3 and ends at 0.
- i_pulse high 20 consecutive cycles:
  - o_pending reaches 15 after edge 18; edge 19 drops one event.
  - o_overflow=1; o_drop_cnt=1 when PULSE_GAP_STATS_EN is defined.
  - Exactly 19 o_pulses total, each 6 cycles apart.
- Pulse arriving on the gap_cnt==0 cycle with o_pending=0 → next o_pulse exactly 6 cycles after the previous one, no idle cycle inserted.
- With o_pending=5, assert i_rst for 1 cycle → all outputs 0 next cycle; no further o_pulse without new input.
- i_ovf_clr asserted in the same cycle as a drop → o_overflow remains 1; a later i_ovf_clr alone → 0.
